// File: rtl/skid_buffer_pkg.sv
// rtl/skid_buffer_pkg.sv - shared state encoding and constants for the skid buffer
package skid_buffer_pkg;

  localparam int SB_COUNT_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } sb_state_t;

  // Occupancy implied by a state; used to register o_count alongside the state.
  function automatic logic [SB_COUNT_W-1:0] sb_count(sb_state_t s);
    logic [SB_COUNT_W-1:0] c;
    c = '0;
    case (s)
      EMPTY:   c = 2'd0;
      BUSY:    c = 2'd1;
      FULL:    c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/skid_buffer_if.sv
// rtl/skid_buffer_if.sv - producer/consumer handshake bundle for the skid buffer
interface skid_buffer_if
  import skid_buffer_pkg::*;
#(
  parameter int WORD_WIDTH = 32
);

  logic                  i_clear;
  logic                  i_valid;
  logic                  i_ready;
  logic [WORD_WIDTH-1:0] i_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [WORD_WIDTH-1:0] o_data;
  logic [SB_COUNT_W-1:0] o_count;

  // Environment side: drives the producer inputs and the consumer ready.
  modport master (
    output i_clear,
    output i_valid,
    output i_data,
    output o_ready,
    input  i_ready,
    input  o_valid,
    input  o_data,
    input  o_count
  );

  modport slave (
    input  i_clear,
    input  i_valid,
    input  i_data,
    input  o_ready,
    output i_ready,
    output o_valid,
    output o_data,
    output o_count
  );

endinterface

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry registered valid/ready slice; every output is a flop
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  skid_buffer_if.slave bus
);

  sb_state_t             state_q, state_d;
  logic                  i_ready_q, i_ready_d;
  logic                  o_valid_q, o_valid_d;
  logic [SB_COUNT_W-1:0] o_count_q, o_count_d;
  logic [WORD_WIDTH-1:0] o_data_q;
  logic [WORD_WIDTH-1:0] skid_q;

  logic in_xfer;
  logic out_xfer;
  logic load_out_from_in;
  logic load_out_from_skid;
  logic load_skid;

  assign in_xfer  = bus.i_valid && i_ready_q;
  assign out_xfer = o_valid_q && bus.o_ready;

  always_comb begin
    state_d            = state_q;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;

    if (bus.i_clear) begin
      // Flush wins over any handshake; data registers keep their contents.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            load_out_from_in = 1'b1;
            state_d          = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            load_out_from_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            load_out_from_skid = 1'b1;
            state_d            = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    i_ready_d = (state_d != FULL);
    o_valid_d = (state_d != EMPTY);
    o_count_d = sb_count(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      i_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_count_q <= '0;
    end else begin
      state_q   <= state_d;
      i_ready_q <= i_ready_d;
      o_valid_q <= o_valid_d;
      o_count_q <= o_count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_data_q <= '0;
      skid_q   <= '0;
    end else begin
      if (load_out_from_in) begin
        o_data_q <= bus.i_data;
      end else if (load_out_from_skid) begin
        o_data_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= bus.i_data;
      end
    end
  end

  assign bus.i_ready = i_ready_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_count = o_count_q;

`ifdef FORMAL
  // Two-word shadow of accepted-but-not-emitted words, in acceptance order.
  logic [WORD_WIDTH-1:0] shadow_q [2];
  logic [1:0]            shadow_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_cnt_q <= '0;
      shadow_q[0]  <= '0;
      shadow_q[1]  <= '0;
    end else if (bus.i_clear) begin
      shadow_cnt_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      shadow_q[shadow_cnt_q[0]] <= bus.i_data;
      shadow_cnt_q              <= shadow_cnt_q + 2'd1;
    end else if (!in_xfer && out_xfer) begin
      shadow_q[0]  <= shadow_q[1];
      shadow_cnt_q <= shadow_cnt_q - 2'd1;
    end else if (in_xfer && out_xfer) begin
      shadow_q[0] <= bus.i_data;
    end
  end

  a_no_ready_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(i_ready_q && o_count_q == 2'd2));
  a_valid_matches_count: assert property (@(posedge clk) disable iff (!reset_n)
    o_valid_q == (o_count_q != 2'd0));
  a_stalled_data_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (o_valid_q && !bus.o_ready) |=> $stable(o_data_q));
  a_word_order: assert property (@(posedge clk) disable iff (!reset_n)
    o_valid_q |-> (o_data_q == shadow_q[0] && o_count_q == shadow_cnt_q));
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// tb/tb_skid_buffer.sv - scoreboard bench: queue-based reference model, directed cases, random soak
module tb_skid_buffer;

  localparam int W = 32;

  logic clk;
  logic reset_n;

  skid_buffer_if #(.WORD_WIDTH(W)) bus ();

  skid_buffer #(.WORD_WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: the buffer is a FIFO of at most two accepted words.
  logic [W-1:0] mq[$];
  bit           rdy_ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_ok <= 1'b0;
    else          rdy_ok <= 1'b1;
  end

  always @(negedge reset_n) mq.delete();

  // Monitor: compare the DUT against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    bit exp_rdy;
    bit exp_val;
    if (!reset_n) begin
      chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
      chk("rst_i_ready", {31'd0, bus.i_ready}, 32'd0);
      chk("rst_o_count", {30'd0, bus.o_count}, 32'd0);
      chk("rst_o_data",  bus.o_data, 32'd0);
    end else begin
      exp_rdy = rdy_ok && (mq.size() < 2);
      exp_val = (mq.size() != 0);
      chk("o_count", {30'd0, bus.o_count}, mq.size());
      chk("o_valid", {31'd0, bus.o_valid}, {31'd0, exp_val});
      chk("i_ready", {31'd0, bus.i_ready}, {31'd0, exp_rdy});
      if (exp_val) chk("o_data", bus.o_data, mq[0]);
      if (bus.i_clear) begin
        mq.delete();
      end else begin
        if (exp_val && bus.o_ready) void'(mq.pop_front());
        if (bus.i_valid && exp_rdy) mq.push_back(bus.i_data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    bit acc;
    logic [W-1:0] word;

    reset_n     = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.o_ready = 1'b0;
    repeat (3) tick();

    // Reset release with a word already offered.
    bus.i_valid = 1'b1;
    bus.i_data  = 32'hA5;
    reset_n     = 1'b1;
    #2;
    chk("t1_ready_low", {31'd0, bus.i_ready}, 32'd0);
    tick();
    chk("t1_ready_high", {31'd0, bus.i_ready}, 32'd1);
    tick();
    chk("t1_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("t1_data", bus.o_data, 32'hA5);
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    tick();

    // Full-rate streaming.
    for (int k = 1; k <= 8; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = k;
      tick();
      chk("t2_count", {30'd0, bus.o_count}, 32'd1);
      chk("t2_data", bus.o_data, k);
    end
    bus.i_valid = 1'b0;
    repeat (2) tick();

    // Fill under stall, then a held word while FULL.
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h10;
    tick();
    bus.i_data  = 32'h11;
    tick();
    bus.i_data  = 32'h99;
    chk("t3_count", {30'd0, bus.o_count}, 32'd2);
    chk("t3_ready", {31'd0, bus.i_ready}, 32'd0);
    repeat (2) tick();
    chk("t4_stable", bus.o_data, 32'h10);
    bus.o_ready = 1'b1;
    tick();
    chk("t3_second", bus.o_data, 32'h11);
    tick();
    bus.i_valid = 1'b0;
    chk("t4_late", bus.o_data, 32'h99);
    repeat (2) tick();
    chk("t4_drained", {30'd0, bus.o_count}, 32'd0);

    // Clear while FULL with both handshakes offered.
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h20;
    tick();
    bus.i_data  = 32'h21;
    tick();
    bus.i_clear = 1'b1;
    bus.i_data  = 32'h22;
    bus.o_ready = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    chk("t5_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("t5_count", {30'd0, bus.o_count}, 32'd0);
    chk("t5_ready", {31'd0, bus.i_ready}, 32'd1);
    tick();
    chk("t5_no_emit", {31'd0, bus.o_valid}, 32'd0);

    // Asynchronous reset pulse while BUSY.
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h30;
    tick();
    bus.i_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("t6_count", {30'd0, bus.o_count}, 32'd0);
    chk("t6_ready", {31'd0, bus.i_ready}, 32'd0);
    #1;
    reset_n = 1'b1;
    repeat (2) tick();
    chk("t6_recover", {31'd0, bus.i_ready}, 32'd1);

    // Random-stall soak.
    sent = 0;
    cyc  = 0;
    word = $urandom;
    while (sent < 10000 && cyc < 60000) begin
      bus.i_valid = 1'($urandom % 2);
      bus.i_data  = word;
      bus.o_ready = 1'($urandom % 2);
      @(negedge clk);
      acc = bus.i_valid && bus.i_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        word = $urandom;
      end
    end
    chk("soak_sent", sent, 10000);
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    repeat (4) tick();
    chk("soak_drained", {30'd0, bus.o_count}, 32'd0);
    chk("soak_model_empty", mq.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
